// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Purpose  : AXI slave in front of a 32-bit wide on-chip SRAM of
//            2**MEM_AW words. Read and write channels are handled by two
//            independent state machines. Each direction accepts one
//            outstanding burst at a time. FIXED bursts (burst=2'b00) hold the
//            word index. Every other burst encoding advances the index by one
//            word per beat. The index wraps modulo the memory depth.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_AW     word-address width; memory depth is 2**MEM_AW words
//   INIT_ZERO  1: memory contents start at zero
// Ports
//   aclk, areset                       clock, async active-high reset
//   arid/araddr/arlen/arsize/arburst   read address channel (arvalid/arready)
//   rid/rdata/rresp/rlast              read data channel (rvalid/rready)
//   awid/awaddr/awlen/awsize/awburst   write address channel (awvalid/awready)
//   wid/wdata/wstrb/wlast              write data channel (wvalid/wready)
//                                      wid is ignored
//   bid/bresp                          write response channel (bvalid/bready)
// Optional feature
//   AXI_SLV_ERR_CHECK_EN  Defining this macro turns on SLVERR responses.
//                         A burst gets SLVERR when its address has bits
//                         above the memory range, or when its size is not
//                         4 bytes. During such a burst, rdata reads as zero
//                         and writes are dropped.
//                         When the macro is not defined, out-of-range
//                         addresses simply wrap.
//                         Transfer sizes other than 4 bytes are treated as
//                         4 bytes.
// ============================================================================
module axi_sram_slave #(
  parameter int MEM_AW    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic        aclk,
  input  logic        areset,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int                DEPTH       = 1 << MEM_AW;
  localparam logic [1:0]        BURST_FIXED = 2'b00;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [MEM_AW-1:0] IDX_ONE     = MEM_AW'(1);
  localparam logic [31:0]       INIT_WORD   = (INIT_ZERO != 0) ? 32'h0 : 32'hx;

  // --------------------------------------------------------------------------
  // Storage. The reset does not touch it: contents survive an areset pulse.
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:DEPTH-1] = '{default: INIT_WORD};

  // --------------------------------------------------------------------------
  // Address decode and optional error detection
  // --------------------------------------------------------------------------
  logic [MEM_AW-1:0] ar_idx;
  logic [MEM_AW-1:0] aw_idx;
  logic              ar_err;
  logic              aw_err;

  assign ar_idx = araddr[MEM_AW+1:2];
  assign aw_idx = awaddr[MEM_AW+1:2];

`ifdef AXI_SLV_ERR_CHECK_EN
  assign ar_err = (araddr[31:MEM_AW+2] != '0) || (arsize != 3'd2);
  assign aw_err = (awaddr[31:MEM_AW+2] != '0) || (awsize != 3'd2);
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  // Some inputs only matter when error checking is enabled.
  // Sub-word address bits and wid are never used.
  logic unused_inputs;
  assign unused_inputs = ^{araddr[31:MEM_AW+2], araddr[1:0], arsize,
                           awaddr[31:MEM_AW+2], awaddr[1:0], awsize, wid};

  // ==========================================================================
  // Read channel
  // ==========================================================================
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  rd_state_t         rd_state;
  rd_state_t         rd_state_nxt;
  logic [7:0]        rd_cnt;      // beats remaining after the current one
  logic [MEM_AW-1:0] rd_idx;
  logic [MEM_AW-1:0] rd_idx_nxt;
  logic [1:0]        rd_burst;
  logic              rd_err;
  logic              ar_hs;
  logic              r_hs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Handshake outputs are decoded from the state register alone.
  // This lets them follow areset with no clock edge.
  always_comb begin
    rd_state_nxt = rd_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (rd_cnt == 8'd0);
        if (rready && (rd_cnt == 8'd0)) begin
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs      = arvalid & arready;
  assign r_hs       = rvalid & rready;
  assign rd_idx_nxt = (rd_burst == BURST_FIXED) ? rd_idx : rd_idx + IDX_ONE;

  // rdata is a register loaded at the AR handshake and at each accepted
  // non-final beat. Because of this, rdata holds steady while the master
  // stalls. A write to the same word on the same edge still returns the
  // old contents.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rid      <= 4'd0;
      rd_cnt   <= 8'd0;
      rd_idx   <= '0;
      rd_burst <= 2'b00;
      rd_err   <= 1'b0;
      rdata    <= 32'd0;
    end else if (ar_hs) begin
      rid      <= arid;
      rd_cnt   <= arlen;
      rd_idx   <= ar_idx;
      rd_burst <= arburst;
      rd_err   <= ar_err;
      rdata    <= ar_err ? 32'd0 : mem[ar_idx];
    end else if (r_hs && (rd_cnt != 8'd0)) begin
      rd_cnt   <= rd_cnt - 8'd1;
      rd_idx   <= rd_idx_nxt;
      rdata    <= rd_err ? 32'd0 : mem[rd_idx_nxt];
    end
  end

  assign rresp = rd_err ? RESP_SLVERR : RESP_OKAY;

  // ==========================================================================
  // Write channel
  // ==========================================================================
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  wr_state_t         wr_state;
  wr_state_t         wr_state_nxt;
  logic [MEM_AW-1:0] wr_idx;
  logic [1:0]        wr_burst;
  logic              wr_err;
  logic              aw_hs;
  logic              w_hs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  // wready is held low until the address has been accepted.
  // A W beat that arrives early waits until then.
  always_comb begin
    wr_state_nxt = wr_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) begin
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bid      <= 4'd0;
      wr_idx   <= '0;
      wr_burst <= 2'b00;
      wr_err   <= 1'b0;
    end else if (aw_hs) begin
      bid      <= awid;
      wr_idx   <= aw_idx;
      wr_burst <= awburst;
      wr_err   <= aw_err;
    end else if (w_hs && (wr_burst != BURST_FIXED)) begin
      wr_idx   <= wr_idx + IDX_ONE;
    end
  end

  assign bresp = wr_err ? RESP_SLVERR : RESP_OKAY;

  // Byte-lane write. w_hs is derived from the asynchronously reset state.
  // So no write can happen while areset is high, even though this block
  // itself has no reset.
  always_ff @(posedge aclk) begin
    if (w_hs && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Purpose  : Directed self-checking bench for axi_sram_slave. It uses the
//            default parameters (MEM_AW=10, INIT_ZERO=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total = 0;
  int bad   = 0;

  // results captured by the stimulus helpers
  logic [31:0] rd_buf [0:15];
  logic [3:0]  rd_id;
  logic [1:0]  rd_resp;
  int          rd_last_cnt;
  int          rd_last_pos;
  int          rd_lat;
  bit          rd_ok;
  logic [31:0] wr_buf [0:15];
  logic [3:0]  wr_strb;
  logic [3:0]  wr_bid;
  logic [1:0]  wr_bresp;
  bit          wr_ok;

  axi_sram_slave dut (
    .aclk    (aclk),
    .areset  (areset),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wid     (wid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after the next rising edge.
  // Inputs are driven there and outputs are sampled there.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write burst using wr_buf/wr_strb.
  // wr_ok drops if any handshake does not happen within its bound.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input int len, input logic [1:0] burst);
    int n;
    wr_ok   = 1'b1;
    awaddr  = addr;
    awid    = id;
    awlen   = 8'(len);
    awsize  = 3'd2;
    awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) wr_ok = 1'b0;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len && wr_ok; i++) begin
      wdata  = wr_buf[i];
      wstrb  = wr_strb;
      wlast  = (i == len);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) wr_ok = 1'b0;
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) wr_ok = 1'b0;
    wr_bid   = bid;
    wr_bresp = bresp;
    bready   = 1'b1;
    tick();
    bready   = 1'b0;
  endtask

  // Full read burst with rready held high.
  // Results go to rd_buf and the rd_* variables.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input int len, input logic [1:0] burst);
    int n;
    rd_ok       = 1'b1;
    rd_last_cnt = 0;
    rd_last_pos = -1;
    araddr  = addr;
    arid    = id;
    arlen   = 8'(len);
    arsize  = 3'd2;
    arburst = burst;
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) rd_ok = 1'b0;
    tick();
    arvalid = 1'b0;
    rd_lat = 0;
    while (!rvalid && rd_lat < 50) begin tick(); rd_lat++; end
    for (int i = 0; i <= len && rd_ok; i++) begin
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      if (!rvalid) begin
        rd_ok = 1'b0;
      end else begin
        rd_buf[i] = rdata;
        if (i == 0) begin
          rd_id   = rid;
          rd_resp = rresp;
        end
        if (rlast) begin
          rd_last_cnt++;
          rd_last_pos = i;
        end
        tick();
      end
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    #2 areset = 1'b1;
    #1;
    // checked before any clock edge: the reset must act asynchronously
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL reset_arready got=%b exp=1", arready); end
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL reset_awready got=%b exp=1", awready); end
    total++; if ({rvalid, wready, bvalid, rlast} !== 4'b0000) begin bad++; $display("FAIL reset_valids got=%b exp=0000", {rvalid, wready, bvalid, rlast}); end
    total++; if ({rid, bid} !== 8'h00) begin bad++; $display("FAIL reset_ids got=%h exp=00", {rid, bid}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    total++; if ({rresp, bresp} !== 4'b0000) begin bad++; $display("FAIL reset_resp got=%b exp=0000", {rresp, bresp}); end
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    wr_buf[0] = 32'hDEADBEEF;
    wr_strb   = 4'hF;
    do_write(32'h10, 4'd3, 0, 2'b01);
    total++; if (!wr_ok) begin bad++; $display("FAIL single_wr_handshake got=timeout exp=complete"); end
    total++; if (wr_bid !== 4'd3 || wr_bresp !== 2'b00) begin bad++; $display("FAIL single_b got=bid %h bresp %b exp=bid 3 bresp 00", wr_bid, wr_bresp); end
    do_read(32'h10, 4'd5, 0, 2'b01);
    total++; if (!rd_ok) begin bad++; $display("FAIL single_rd_handshake got=timeout exp=complete"); end
    total++; if (rd_buf[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rd_buf[0]); end
    total++; if (rd_id !== 4'd5 || rd_resp !== 2'b00) begin bad++; $display("FAIL single_rid got=rid %h rresp %b exp=rid 5 rresp 00", rd_id, rd_resp); end
    total++; if (rd_last_cnt != 1 || rd_last_pos != 0) begin bad++; $display("FAIL single_rlast got=cnt %0d pos %0d exp=cnt 1 pos 0", rd_last_cnt, rd_last_pos); end
    total++; if (rd_lat != 0) begin bad++; $display("FAIL single_latency got=%0d extra cycles exp=0", rd_lat); end
  endtask

  task automatic test_incr_stall();
    int n;
    int k;
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'(i + 1);
    wr_strb = 4'hF;
    do_write(32'h100, 4'd1, 3, 2'b01);
    total++; if (!wr_ok || wr_bresp !== 2'b00) begin bad++; $display("FAIL incr_write got=ok %0d bresp %b exp=ok 1 bresp 00", wr_ok, wr_bresp); end
    araddr  = 32'h100;
    arid    = 4'd2;
    arlen   = 8'd3;
    arsize  = 3'd2;
    arburst = 2'b01;
    arvalid = 1'b1;
    rready  = 1'b0;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    // rready pattern 1,0,1,0,...: odd cycles are stalls, so the beat shown
    // there must match the following accept cycle.
    for (int c = 0; c < 7; c++) begin
      k = (c + 1) / 2;
      rready = (c % 2 == 0);
      total++; if (rvalid !== 1'b1 || rdata !== 32'(k + 1)) begin bad++; $display("FAIL incr_beat c%0d got=valid %b data %h exp=valid 1 data %h", c, rvalid, rdata, 32'(k + 1)); end
      total++; if (rlast !== (k == 3)) begin bad++; $display("FAIL incr_rlast c%0d got=%b exp=%b", c, rlast, (k == 3)); end
      tick();
    end
    rready = 1'b0;
    total++; if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++; $display("FAIL incr_end got=rvalid %b arready %b exp=0 1", rvalid, arready); end
  endtask

  task automatic test_strobe();
    wr_buf[0] = 32'h11223344;
    wr_strb   = 4'hF;
    do_write(32'h20, 4'd0, 0, 2'b01);
    wr_buf[0] = 32'hAABBCCDD;
    wr_strb   = 4'h5;
    do_write(32'h20, 4'd0, 0, 2'b01);
    do_read(32'h20, 4'd0, 0, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd_buf[0]); end
  endtask

  task automatic test_early_w();
    int n;
    wdata  = 32'hCAFEF00D;
    wstrb  = 4'hF;
    wlast  = 1'b1;
    wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++; if (wready !== 1'b0) begin bad++; $display("FAIL early_w_wait c%0d got=%b exp=0", c, wready); end
      tick();
    end
    awaddr  = 32'h40;
    awid    = 4'd7;
    awlen   = 8'd0;
    awsize  = 3'd2;
    awburst = 2'b01;
    awvalid = 1'b1;
    total++; if (wready !== 1'b0 || awready !== 1'b1) begin bad++; $display("FAIL early_w_aw_cycle got=wready %b awready %b exp=0 1", wready, awready); end
    tick();
    awvalid = 1'b0;
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL early_w_ready got=%b exp=1", wready); end
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    total++; if (bvalid !== 1'b1 || bid !== 4'd7) begin bad++; $display("FAIL early_w_b got=bvalid %b bid %h exp=1 7", bvalid, bid); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    do_read(32'h40, 4'd1, 0, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL early_w_data got=%h exp=cafef00d", rd_buf[0]); end
  endtask

  task automatic test_fixed();
    wr_buf[0] = 32'd7;
    wr_buf[1] = 32'd8;
    wr_buf[2] = 32'd9;
    wr_strb   = 4'hF;
    do_write(32'h80, 4'd2, 2, 2'b00);
    do_read(32'h80, 4'd2, 1, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'd9 || rd_buf[1] !== 32'd0) begin bad++; $display("FAIL fixed_write got=%h %h exp=00000009 00000000", rd_buf[0], rd_buf[1]); end
    do_read(32'h80, 4'd2, 1, 2'b00);
    total++; if (!rd_ok || rd_buf[0] !== 32'd9 || rd_buf[1] !== 32'd9) begin bad++; $display("FAIL fixed_read got=%h %h exp=00000009 00000009", rd_buf[0], rd_buf[1]); end
  endtask

  task automatic test_collision();
    int n;
    wr_buf[0] = 32'h11112222;
    wr_strb   = 4'hF;
    do_write(32'h300, 4'd0, 0, 2'b01);
    awaddr  = 32'h300;
    awid    = 4'd1;
    awlen   = 8'd0;
    awsize  = 3'd2;
    awburst = 2'b01;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    wdata   = 32'h33334444;
    wstrb   = 4'hF;
    wlast   = 1'b1;
    wvalid  = 1'b1;
    araddr  = 32'h300;
    arid    = 4'd2;
    arlen   = 8'd0;
    arsize  = 3'd2;
    arburst = 2'b01;
    arvalid = 1'b1;
    rready  = 1'b0;
    total++; if (wready !== 1'b1 || arready !== 1'b1) begin bad++; $display("FAIL collide_setup got=wready %b arready %b exp=1 1", wready, arready); end
    tick();
    wvalid  = 1'b0;
    wlast   = 1'b0;
    arvalid = 1'b0;
    total++; if (rvalid !== 1'b1 || rdata !== 32'h11112222) begin bad++; $display("FAIL collide_old got=valid %b data %h exp=valid 1 data 11112222", rvalid, rdata); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    do_read(32'h300, 4'd0, 0, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'h33334444) begin bad++; $display("FAIL collide_new got=%h exp=33334444", rd_buf[0]); end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'hA5A50000 + 32'(i);
    wr_strb = 4'hF;
    do_write(32'h200, 4'd0, 3, 2'b01);
    araddr  = 32'h200;
    arid    = 4'd9;
    arlen   = 8'd3;
    arsize  = 3'd2;
    arburst = 2'b01;
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    tick();
    total++; if (rvalid !== 1'b1 || rdata !== 32'hA5A50001) begin bad++; $display("FAIL rstmid_beat2 got=valid %b data %h exp=valid 1 data a5a50001", rvalid, rdata); end
    #2 areset = 1'b1;
    #1;
    total++; if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=rvalid %b arready %b rlast %b exp=0 1 0", rvalid, arready, rlast); end
    total++; if (rdata !== 32'h0 || rid !== 4'd0) begin bad++; $display("FAIL rstmid_data got=rdata %h rid %h exp=0 0", rdata, rid); end
    rready = 1'b0;
    tick();
    areset = 1'b0;
    tick();
    do_read(32'h204, 4'd4, 1, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'hA5A50001 || rd_buf[1] !== 32'hA5A50002) begin bad++; $display("FAIL rstmid_reread got=%h %h exp=a5a50001 a5a50002", rd_buf[0], rd_buf[1]); end
  endtask

  task automatic test_wrap();
    wr_buf[0] = 32'h55;
    wr_buf[1] = 32'h66;
    wr_strb   = 4'hF;
    do_write(32'hFFC, 4'd0, 1, 2'b01);
    do_read(32'h000, 4'd0, 0, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'h66) begin bad++; $display("FAIL wrap_write got=%h exp=00000066", rd_buf[0]); end
    do_read(32'hFFC, 4'd0, 1, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'h55 || rd_buf[1] !== 32'h66) begin bad++; $display("FAIL wrap_read got=%h %h exp=00000055 00000066", rd_buf[0], rd_buf[1]); end
    do_read(32'h1000, 4'd0, 0, 2'b01);
`ifdef AXI_SLV_ERR_CHECK_EN
    total++; if (!rd_ok || rd_resp !== 2'b10 || rd_buf[0] !== 32'h0) begin bad++; $display("FAIL range_read got=resp %b data %h exp=resp 10 data 0", rd_resp, rd_buf[0]); end
    wr_buf[0] = 32'h77;
    do_write(32'h1000, 4'd0, 0, 2'b01);
    total++; if (!wr_ok || wr_bresp !== 2'b10) begin bad++; $display("FAIL range_write got=bresp %b exp=10", wr_bresp); end
    do_read(32'h000, 4'd0, 0, 2'b01);
    total++; if (!rd_ok || rd_buf[0] !== 32'h66) begin bad++; $display("FAIL range_unchanged got=%h exp=00000066", rd_buf[0]); end
`else
    total++; if (!rd_ok || rd_resp !== 2'b00 || rd_buf[0] !== 32'h66) begin bad++; $display("FAIL range_alias got=resp %b data %h exp=resp 00 data 66", rd_resp, rd_buf[0]); end
`endif
  endtask

  initial begin
    areset  = 1'b0;
    arid    = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b0; rready = 1'b0;
    awid    = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b0;
    wid     = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready  = 1'b0;
    test_reset();
    test_single();
    test_incr_stall();
    test_strobe();
    test_early_w();
    test_fixed();
    test_collision();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
